// File: rtl/mc_datapath_param.sv
// Parametrised multicycle CPU datapath: PC, IR, MDR, A, B, ALUOut, register file, ALU and steering muxes.
// All sequencing comes from the external control FSM; this block holds no control state of its own.
module mc_datapath_param #(
    parameter int           W         = 32,
    parameter int           REG_COUNT = 32,
    parameter logic [W-1:0] RESET_PC  = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         pc_write,
    input  logic         branch,
    input  logic         branch_ne,
    input  logic         ir_write,
    input  logic         alu_src_a,
    input  logic [1:0]   alu_src_b,
    input  logic [2:0]   alu_control,
    input  logic [1:0]   pc_source,
    input  logic         reg_file_enable,
    input  logic         reg_dst,
    input  logic         mem_to_reg,
    input  logic         data_mem_enable,
    output logic [W-1:0] imem_addr,
    input  logic [31:0]  imem_rdata,
    output logic [W-1:0] dmem_addr,
    output logic [W-1:0] dmem_wdata,
    output logic         dmem_we,
    input  logic [W-1:0] dmem_rdata,
    output logic [5:0]   opcode,
    output logic [5:0]   funct,
    output logic         zero,
    output logic [W-1:0] alu_result
);
    localparam int RA = $clog2(REG_COUNT);

    function automatic logic [W-1:0] alu_op(input logic [2:0] op,
                                            input logic signed [W-1:0] x,
                                            input logic signed [W-1:0] y);
        case (op)
            3'b000:  return x & y;
            3'b001:  return x | y;
            3'b010:  return x + y;
            3'b110:  return x - y;
            3'b111:  return {{(W-1){1'b0}}, (x < y)};
            3'b101:  return {{(W-1){1'b0}}, ($unsigned(x) < $unsigned(y))};
            3'b011:  return x ^ y;
            3'b100:  return ~(x | y);
            default: return '0;
        endcase
    endfunction

    function automatic logic [W-1:0] sext16(input logic [15:0] v);
        return {{(W-16){v[15]}}, v};
    endfunction

    logic [W-1:0]  pc, mdr, a, b, alu_out;
    logic [31:0]   ir;
    logic [W-1:0]  rf [REG_COUNT];
    logic [RA-1:0] rs, rt, rd, wr_addr;
    logic [W-1:0]  rs_data, rt_data, wr_data;
    logic [W-1:0]  imm_ext, imm_sh, src_a, src_b, jump_target, pc_next;
    logic          pc_load;

    // Register fields are truncated to the implemented address width
    assign rs      = ir[21 +: RA];
    assign rt      = ir[16 +: RA];
    assign rd      = ir[11 +: RA];
    assign wr_addr = reg_dst ? rd : rt;
    assign wr_data = mem_to_reg ? mdr : alu_out;
    assign rs_data = (rs == '0) ? '0 : rf[rs];
    assign rt_data = (rt == '0) ? '0 : rf[rt];

    assign imm_ext     = sext16(ir[15:0]);
    assign imm_sh      = imm_ext << 2;
    assign jump_target = {pc[W-1:28], ir[25:0], 2'b00};
    assign src_a       = alu_src_a ? a : pc;

    always_comb begin
        src_b = b;
        case (alu_src_b)
            2'b00: src_b = b;
            2'b01: src_b = W'(4);
            2'b10: src_b = imm_ext;
            2'b11: src_b = imm_sh;
        endcase
    end

    assign alu_result = alu_op(alu_control, src_a, src_b);
    assign zero       = (alu_result == '0);
    assign pc_load    = pc_write | (branch & (zero ^ branch_ne));

    always_comb begin
        pc_next = alu_result;
        case (pc_source)
            2'b00: pc_next = alu_result;
            2'b01: pc_next = alu_out;
            2'b10: pc_next = jump_target;
            2'b11: pc_next = a;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc      <= RESET_PC;
            ir      <= '0;
            mdr     <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
        end else begin
            if (pc_load)
                pc <= pc_next;
            if (ir_write)
                ir <= imem_rdata;
            mdr     <= dmem_rdata;
            a       <= rs_data;
            b       <= rt_data;
            alu_out <= alu_result;
        end
    end

    // Reads are combinational and see the pre-write value during a write cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++)
                rf[i] <= '0;
        end else if (reg_file_enable && (wr_addr != '0)) begin
            rf[wr_addr] <= wr_data;
        end
    end

    assign imem_addr  = pc;
    assign dmem_addr  = alu_out;
    assign dmem_wdata = b;
    assign dmem_we    = data_mem_enable;
    assign opcode     = ir[31:26];
    assign funct      = ir[5:0];
endmodule

// File: tb/tb_mc_datapath_param.sv
// Scoreboard bench for mc_datapath_param: a 32-bit/32-register instance and a 64-bit/8-register
// instance with RESET_PC=0x100 share every control input and run in lockstep.
module tb_mc_datapath_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, pc_write, branch, branch_ne, ir_write, alu_src_a;
    logic [1:0]  alu_src_b, pc_source;
    logic [2:0]  alu_control;
    logic        reg_file_enable, reg_dst, mem_to_reg, data_mem_enable;
    logic [31:0] imem_rdata;
    logic [31:0] dmem_rdata32;
    logic [63:0] dmem_rdata64;

    logic [31:0] imem_addr32, dmem_addr32, dmem_wdata32, alu_result32;
    logic [63:0] imem_addr64, dmem_addr64, dmem_wdata64, alu_result64;
    logic        dmem_we32, zero32, dmem_we64, zero64;
    logic [5:0]  opcode32, funct32, opcode64, funct64;

    mc_datapath_param #(.W(32), .REG_COUNT(32), .RESET_PC(32'h0)) u32 (
        .clk(clk), .reset(reset), .pc_write(pc_write), .branch(branch), .branch_ne(branch_ne),
        .ir_write(ir_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
        .pc_source(pc_source), .reg_file_enable(reg_file_enable), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .data_mem_enable(data_mem_enable), .imem_addr(imem_addr32),
        .imem_rdata(imem_rdata), .dmem_addr(dmem_addr32), .dmem_wdata(dmem_wdata32),
        .dmem_we(dmem_we32), .dmem_rdata(dmem_rdata32), .opcode(opcode32), .funct(funct32),
        .zero(zero32), .alu_result(alu_result32)
    );

    mc_datapath_param #(.W(64), .REG_COUNT(8), .RESET_PC(64'h100)) u64 (
        .clk(clk), .reset(reset), .pc_write(pc_write), .branch(branch), .branch_ne(branch_ne),
        .ir_write(ir_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
        .pc_source(pc_source), .reg_file_enable(reg_file_enable), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .data_mem_enable(data_mem_enable), .imem_addr(imem_addr64),
        .imem_rdata(imem_rdata), .dmem_addr(dmem_addr64), .dmem_wdata(dmem_wdata64),
        .dmem_we(dmem_we64), .dmem_rdata(dmem_rdata64), .opcode(opcode64), .funct(funct64),
        .zero(zero64), .alu_result(alu_result64)
    );

    string       sb_name[$];
    logic [63:0] sb_val[$];
    logic [63:0] obs[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] pc32;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pc_write = 0; branch = 0; branch_ne = 0; ir_write = 0; alu_src_a = 0;
        alu_src_b = 2'b00; alu_control = 3'b000; pc_source = 2'b00;
        reg_file_enable = 0; reg_dst = 0; mem_to_reg = 0; data_mem_enable = 0;
    endtask

    task automatic expect_val(input string n, input logic [63:0] v);
        sb_name.push_back(n);
        sb_val.push_back(v);
    endtask

    task automatic load_ir(input logic [31:0] w);
        idle();
        imem_rdata = w;
        ir_write = 1;
        tick();
        ir_write = 0;
    endtask

    // Leaves A=rf[rs], B=rf[rt] in place for the following cycles
    task automatic set_ops(input logic [4:0] rs, input logic [4:0] rt);
        load_ir({6'h00, rs, rt, 16'h0000});
        tick();
    endtask

    // Writes through MDR: rt field selects the register, dmem_rdata supplies the data
    task automatic write_reg(input logic [4:0] r, input logic [31:0] v32, input logic [63:0] v64);
        dmem_rdata32 = v32;
        dmem_rdata64 = v64;
        load_ir({6'h23, 5'd0, r, 16'h0000});
        reg_dst = 0; mem_to_reg = 1; reg_file_enable = 1;
        tick();
        idle();
    endtask

    task automatic test_reset();
        logic [63:0] o, v; string n;
        #1 reset = 1;
        expect_val("rst_pc32", 64'h0);
        expect_val("rst_pc64", 64'h100);
        expect_val("rst_opcode", 64'h0);
        expect_val("rst_dmem_addr", 64'h0);
        expect_val("rst_dmem_wdata", 64'h0);
        #2;
        obs.push_back({32'h0, imem_addr32});
        obs.push_back(imem_addr64);
        obs.push_back({58'h0, opcode64});
        obs.push_back(dmem_addr64);
        obs.push_back(dmem_wdata64);
        reset = 0;
        tick();
        expect_val("release_pc64", 64'h100);
        obs.push_back(imem_addr64);
        load_ir(32'h08000010);
        pc_source = 2'b10; pc_write = 1;
        expect_val("jump_to_40", 64'h40);
        tick();
        obs.push_back({32'h0, imem_addr32});
        idle();
        #2 reset = 1;
        expect_val("mid_rst_pc32", 64'h0);
        expect_val("mid_rst_opcode", 64'h0);
        expect_val("mid_rst_pc64", 64'h100);
        #1;
        obs.push_back({32'h0, imem_addr32});
        obs.push_back({58'h0, opcode32});
        obs.push_back(imem_addr64);
        reset = 0;
        tick();
        expect_val("rerelease_pc64", 64'h100);
        obs.push_back(imem_addr64);
        pc32 = 32'h0;
        while (obs.size() > 0) begin
            total++;
            o = obs.pop_front(); n = sb_name.pop_front(); v = sb_val.pop_front();
            if (o !== v) begin bad++; $display("FAIL %s: got 0x%0h expected 0x%0h", n, o, v); end
        end
    endtask

    task automatic test_fetch();
        logic [63:0] o, v; string n;
        idle();
        alu_src_b = 2'b01; alu_control = 3'b010; pc_write = 1; ir_write = 1;
        imem_rdata = 32'h012A4020;
        expect_val("fetch_alu", {32'h0, pc32 + 32'd4});
        #1 obs.push_back({32'h0, alu_result32});
        expect_val("fetch_pc32", {32'h0, pc32 + 32'd4});
        expect_val("fetch_pc64", 64'h104);
        expect_val("fetch_opcode", 64'h0);
        expect_val("fetch_funct32", 64'h20);
        expect_val("fetch_funct64", 64'h20);
        tick();
        obs.push_back({32'h0, imem_addr32});
        obs.push_back(imem_addr64);
        obs.push_back({58'h0, opcode32});
        obs.push_back({58'h0, funct32});
        obs.push_back({58'h0, funct64});
        pc32 = pc32 + 32'd4;
        idle();
        while (obs.size() > 0) begin
            total++;
            o = obs.pop_front(); n = sb_name.pop_front(); v = sb_val.pop_front();
            if (o !== v) begin bad++; $display("FAIL %s: got 0x%0h expected 0x%0h", n, o, v); end
        end
    endtask

    task automatic test_rtype_add();
        logic [63:0] o, v; string n;
        write_reg(5'd9, 32'd5, 64'd5);
        write_reg(5'd10, 32'd7, 64'd7);
        load_ir(32'h012A4020);
        tick();
        alu_src_a = 1; alu_control = 3'b010; data_mem_enable = 1;
        expect_val("add_alu", 64'd12);
        expect_val("dmem_we32_on", 64'd1);
        expect_val("dmem_we64_on", 64'd1);
        #1;
        obs.push_back({32'h0, alu_result32});
        obs.push_back({63'h0, dmem_we32});
        obs.push_back({63'h0, dmem_we64});
        tick();
        expect_val("add_aluout", 64'd12);
        expect_val("add_wdata", 64'd7);
        obs.push_back({32'h0, dmem_addr32});
        obs.push_back({32'h0, dmem_wdata32});
        data_mem_enable = 0; reg_dst = 1; mem_to_reg = 0; reg_file_enable = 1;
        tick();
        idle();
        expect_val("dmem_we_off", 64'd0);
        obs.push_back({63'h0, dmem_we32});
        set_ops(5'd8, 5'd0);
        alu_src_a = 1; alu_control = 3'b001;
        expect_val("rf8_readback", 64'd12);
        #1 obs.push_back({32'h0, alu_result32});
        write_reg(5'd0, 32'h55, 64'h55);
        set_ops(5'd0, 5'd0);
        alu_src_a = 1; alu_control = 3'b001;
        expect_val("rf0_reads_zero", 64'd0);
        #1 obs.push_back({32'h0, alu_result32});
        idle();
        while (obs.size() > 0) begin
            total++;
            o = obs.pop_front(); n = sb_name.pop_front(); v = sb_val.pop_front();
            if (o !== v) begin bad++; $display("FAIL %s: got 0x%0h expected 0x%0h", n, o, v); end
        end
    endtask

    task automatic test_branch();
        logic [63:0] o, v; string n;
        write_reg(5'd1, 32'd3, 64'd3);
        write_reg(5'd2, 32'd3, 64'd3);
        load_ir({6'h04, 5'd1, 5'd2, 16'd4});
        tick();
        alu_src_b = 2'b11; alu_control = 3'b010;
        tick();
        alu_src_a = 1; alu_src_b = 2'b00; alu_control = 3'b110;
        branch = 1; branch_ne = 0; pc_source = 2'b01;
        expect_val("beq_zero", 64'd1);
        #1 obs.push_back({63'h0, zero32});
        expect_val("beq_taken_pc", {32'h0, pc32 + 32'd16});
        tick();
        obs.push_back({32'h0, imem_addr32});
        pc32 = pc32 + 32'd16;
        branch_ne = 1;
        expect_val("bne_equal_hold", {32'h0, pc32});
        tick();
        obs.push_back({32'h0, imem_addr32});
        idle();
        write_reg(5'd2, 32'd4, 64'd4);
        load_ir({6'h05, 5'd1, 5'd2, 16'd4});
        tick();
        alu_src_b = 2'b11; alu_control = 3'b010;
        tick();
        alu_src_a = 1; alu_src_b = 2'b00; alu_control = 3'b110;
        branch = 1; branch_ne = 1; pc_source = 2'b01;
        expect_val("bne_zero", 64'd0);
        #1 obs.push_back({63'h0, zero32});
        expect_val("bne_taken_pc", {32'h0, pc32 + 32'd16});
        tick();
        obs.push_back({32'h0, imem_addr32});
        pc32 = pc32 + 32'd16;
        idle();
        while (obs.size() > 0) begin
            total++;
            o = obs.pop_front(); n = sb_name.pop_front(); v = sb_val.pop_front();
            if (o !== v) begin bad++; $display("FAIL %s: got 0x%0h expected 0x%0h", n, o, v); end
        end
    endtask

    task automatic test_alu_edges();
        logic [63:0] o, v; string n;
        write_reg(5'd3, 32'hFFFF_FFFF, 64'h0000_0000_FFFF_FFFF);
        write_reg(5'd4, 32'd1, 64'd1);
        set_ops(5'd3, 5'd4);
        alu_src_a = 1; alu_control = 3'b010;
        expect_val("add_wrap32", 64'h0);
        expect_val("add_wrap_zero32", 64'd1);
        expect_val("add_carry64", 64'h1_0000_0000);
        expect_val("add_zero64", 64'd0);
        #1;
        obs.push_back({32'h0, alu_result32});
        obs.push_back({63'h0, zero32});
        obs.push_back(alu_result64);
        obs.push_back({63'h0, zero64});
        write_reg(5'd3, 32'h8000_0000, 64'hFFFF_FFFF_8000_0000);
        set_ops(5'd3, 5'd4);
        alu_src_a = 1; alu_control = 3'b111;
        expect_val("slt32", 64'd1);
        expect_val("slt64", 64'd1);
        #1;
        obs.push_back({32'h0, alu_result32});
        obs.push_back(alu_result64);
        alu_control = 3'b101;
        expect_val("sltu32", 64'd0);
        expect_val("sltu64", 64'd0);
        #1;
        obs.push_back({32'h0, alu_result32});
        obs.push_back(alu_result64);
        alu_control = 3'b011;
        expect_val("xor32", 64'h8000_0001);
        #1 obs.push_back({32'h0, alu_result32});
        alu_control = 3'b000;
        expect_val("and32", 64'h0);
        #1 obs.push_back({32'h0, alu_result32});
        set_ops(5'd0, 5'd0);
        alu_src_a = 1; alu_control = 3'b100;
        expect_val("nor32", 64'hFFFF_FFFF);
        expect_val("nor64", 64'hFFFF_FFFF_FFFF_FFFF);
        #1;
        obs.push_back({32'h0, alu_result32});
        obs.push_back(alu_result64);
        idle();
        while (obs.size() > 0) begin
            total++;
            o = obs.pop_front(); n = sb_name.pop_front(); v = sb_val.pop_front();
            if (o !== v) begin bad++; $display("FAIL %s: got 0x%0h expected 0x%0h", n, o, v); end
        end
    endtask

    task automatic test_jump();
        logic [63:0] o, v; string n;
        write_reg(5'd6, 32'h1000_0000, 64'hABCD_0000_1000_0000);
        set_ops(5'd6, 5'd0);
        pc_source = 2'b11; pc_write = 1;
        expect_val("jr_pc32", 64'h1000_0000);
        expect_val("jr_pc64", 64'hABCD_0000_1000_0000);
        tick();
        obs.push_back({32'h0, imem_addr32});
        obs.push_back(imem_addr64);
        load_ir(32'h08000010);
        pc_source = 2'b10; pc_write = 1;
        expect_val("j_pc32", 64'h1000_0040);
        expect_val("j_pc64", 64'hABCD_0000_1000_0040);
        tick();
        obs.push_back({32'h0, imem_addr32});
        obs.push_back(imem_addr64);
        idle();
        write_reg(5'd6, 32'h200, 64'h200);
        set_ops(5'd6, 5'd0);
        pc_source = 2'b11; pc_write = 1;
        expect_val("jr200_pc32", 64'h200);
        expect_val("jr200_pc64", 64'h200);
        tick();
        obs.push_back({32'h0, imem_addr32});
        obs.push_back(imem_addr64);
        idle();
        while (obs.size() > 0) begin
            total++;
            o = obs.pop_front(); n = sb_name.pop_front(); v = sb_val.pop_front();
            if (o !== v) begin bad++; $display("FAIL %s: got 0x%0h expected 0x%0h", n, o, v); end
        end
    endtask

    task automatic test_w64_regs();
        logic [63:0] o, v; string n;
        write_reg(5'd1, 32'd1, 64'h0000_0001_FFFF_FFFF);
        write_reg(5'd2, 32'd1, 64'h1);
        load_ir({6'h00, 5'd1, 5'd2, 5'd13, 5'd0, 6'h20});
        tick();
        alu_src_a = 1; alu_control = 3'b010;
        tick();
        reg_dst = 1; mem_to_reg = 0; reg_file_enable = 1;
        tick();
        idle();
        set_ops(5'd5, 5'd0);
        alu_src_a = 1; alu_control = 3'b001;
        expect_val("rd13_to_reg5_64", 64'h0000_0002_0000_0000);
        #1 obs.push_back(alu_result64);
        idle();
        while (obs.size() > 0) begin
            total++;
            o = obs.pop_front(); n = sb_name.pop_front(); v = sb_val.pop_front();
            if (o !== v) begin bad++; $display("FAIL %s: got 0x%0h expected 0x%0h", n, o, v); end
        end
    endtask

    initial begin
        reset = 0;
        idle();
        imem_rdata   = 32'h0;
        dmem_rdata32 = 32'h0;
        dmem_rdata64 = 64'h0;
        pc32         = 32'h0;
        test_reset();
        test_fetch();
        test_rtype_add();
        test_branch();
        test_alu_edges();
        test_jump();
        test_w64_regs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
